dreg_bank: RTL and testbench

- Parametrised, clocked successor to the single-bit NAND D-latch.
- Holds CHANNELS independent WIDTH-bit data registers, each with its own enable, and drives true and complement outputs.
- A selectable transparent mode gives latch-like flow-through while keeping synchronous storage.
- Per-channel change detection feeds a saturating update counter, used by the board-level logic for activity monitoring.

---
 rtl/dreg_bank.sv | 93 +++++++++
 tb/tb_dreg_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dreg_bank.sv
// dreg_bank: CHANNELS independent WIDTH-bit enabled registers with true/complement outputs,
// optional transparent flow-through, change pulses and a saturating update counter.
// Optional feature: define DREG_BANK_PARITY_EN to add the per-channel parity output 'par'.
module dreg_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       En,
  input  logic [CHANNELS*WIDTH-1:0] D,
  input  logic                      mode,
  input  logic                      cnt_clr,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [CHANNELS*WIDTH-1:0] not_Q,
  output logic [CHANNELS-1:0]       changed,
  output logic [CNT_W-1:0]          upd_count
`ifdef DREG_BANK_PARITY_EN
  ,
  output logic [CHANNELS-1:0]       par
`endif
);

  // The extra headroom bits let the sum exceed MAX without wrapping before saturation.
  localparam int SUM_W = CNT_W + $clog2(CHANNELS + 1);
  localparam logic [SUM_W-1:0] MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [CHANNELS*WIDTH-1:0] stored;
  logic [CHANNELS*WIDTH-1:0] next_stored;
  logic [CHANNELS-1:0]       chg;
  logic [SUM_W-1:0]          n_chg;
  logic [SUM_W-1:0]          cnt_sum;
  logic [CNT_W-1:0]          cnt_next;
`ifdef DREG_BANK_PARITY_EN
  logic [CHANNELS-1:0]       next_par;
`endif

  always_comb begin
    next_stored = stored;
    chg         = '0;
    n_chg       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (En[i]) begin
        next_stored[i*WIDTH +: WIDTH] = D[i*WIDTH +: WIDTH];
        chg[i] = (D[i*WIDTH +: WIDTH] != stored[i*WIDTH +: WIDTH]);
      end
      n_chg = n_chg + SUM_W'(chg[i]);
    end
    cnt_sum  = (cnt_clr ? '0 : SUM_W'(upd_count)) + n_chg;
    cnt_next = (cnt_sum > MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

`ifdef DREG_BANK_PARITY_EN
  always_comb begin
    next_par = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      next_par[i] = ^next_stored[i*WIDTH +: WIDTH];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stored    <= '0;
      changed   <= '0;
      upd_count <= '0;
`ifdef DREG_BANK_PARITY_EN
      par       <= '0;
`endif
    end else begin
      stored    <= next_stored;
      changed   <= chg;
      upd_count <= cnt_next;
`ifdef DREG_BANK_PARITY_EN
      par       <= next_par;
`endif
    end
  end

  // Transparent channels bypass storage only while enabled and out of reset.
  always_comb begin
    Q = stored;
    for (int i = 0; i < CHANNELS; i++) begin
      if (mode && En[i] && rst_n) begin
        Q[i*WIDTH +: WIDTH] = D[i*WIDTH +: WIDTH];
      end
    end
  end

  assign not_Q = ~Q;

endmodule

// File: tb/tb_dreg_bank.sv
// Self-checking bench for dreg_bank (WIDTH=8, CHANNELS=4, CNT_W=4): a per-channel array model
// checked every cycle, plus directed vectors with hand-computed expectations.
module tb_dreg_bank;

  logic        clk;
  logic        rst_n;
  logic [3:0]  En;
  logic [31:0] D;
  logic        mode;
  logic        cnt_clr;
  logic [31:0] Q;
  logic [31:0] not_Q;
  logic [3:0]  changed;
  logic [3:0]  upd_count;
`ifdef DREG_BANK_PARITY_EN
  logic [3:0]  par;
`endif

  int checks   = 0;
  int failures = 0;
  bit compare_en = 0;

  // Behavioural model: one byte per channel, a plain integer counter.
  logic [7:0] m_store [4];
  logic [3:0] m_chg;
  int         m_cnt;

  dreg_bank #(.WIDTH(8), .CHANNELS(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .En        (En),
    .D         (D),
    .mode      (mode),
    .cnt_clr   (cnt_clr),
    .Q         (Q),
    .not_Q     (not_Q),
    .changed   (changed),
    .upd_count (upd_count)
`ifdef DREG_BANK_PARITY_EN
    ,
    .par       (par)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] en, input logic [31:0] d, input logic md,
                               input logic clr, input logic rn);
    En = en; D = d; mode = md; cnt_clr = clr; rst_n = rn;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_store[i] = 8'h00;
      m_chg = 4'h0;
      m_cnt = 0;
    end else begin
      int n;
      int base;
      n = 0;
      for (int i = 0; i < 4; i++) begin
        m_chg[i] = En[i] && (D[i*8 +: 8] != m_store[i]);
        if (m_chg[i]) n++;
        if (En[i]) m_store[i] = D[i*8 +: 8];
      end
      base  = cnt_clr ? 0 : m_cnt;
      m_cnt = (base + n > 15) ? 15 : base + n;
    end
    compare_en = 1;
  end

  always @(negedge clk) begin
    if (compare_en) begin
      logic [31:0] exp_q;
      logic [3:0]  exp_par;
      for (int i = 0; i < 4; i++) begin
        exp_q[i*8 +: 8] = (mode && En[i] && rst_n) ? D[i*8 +: 8] : m_store[i];
        exp_par[i]      = ^m_store[i];
      end
      checkOutput("model_Q", Q, exp_q);
      checkOutput("model_not_Q", not_Q, ~exp_q);
      checkOutput("model_changed", {28'h0, changed}, {28'h0, m_chg});
      checkOutput("model_upd_count", {28'h0, upd_count}, m_cnt);
`ifdef DREG_BANK_PARITY_EN
      checkOutput("model_par", {28'h0, par}, {28'h0, exp_par});
`endif
    end
  end

  initial begin
    logic [4:0] sat_exp [5];
    sat_exp = '{5'd4, 5'd8, 5'd12, 5'd15, 5'd15};

    // Reset for two edges with everything enabled.
    applyStimulus(4'hF, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_Q", Q, 32'h0);
    checkOutput("reset_not_Q", not_Q, 32'hFFFFFFFF);
    checkOutput("reset_changed", {28'h0, changed}, 32'h0);
    checkOutput("reset_count", {28'h0, upd_count}, 32'h0);

    // Registered capture with one cycle of latency.
    applyStimulus(4'b0101, 32'h11223344, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("reg_latency_Q", Q, 32'h0);
    tick();
    checkOutput("reg_Q", Q, 32'h00220044);
    checkOutput("reg_changed", {28'h0, changed}, 32'h5);
    checkOutput("reg_count", {28'h0, upd_count}, 32'd2);
    applyStimulus(4'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("hold_Q", Q, 32'h00220044);
    checkOutput("hold_changed", {28'h0, changed}, 32'h0);

    // Transparent flow-through on channel 0.
    applyStimulus(4'b0001, 32'h0022003C, 1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("transp_3C", Q, 32'h0022003C);
    D = 32'h0022007E;
    #1;
    checkOutput("transp_7E", Q, 32'h0022007E);
    tick();
    checkOutput("transp_changed", {28'h0, changed}, 32'h1);
    checkOutput("transp_count", {28'h0, upd_count}, 32'd3);
    applyStimulus(4'b0000, 32'h00220000, 1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("freeze_Q", Q, 32'h0022007E);
    checkOutput("freeze_not_Q", not_Q, 32'hFFDDFF81);
    tick();
    checkOutput("freeze_Q_after_edge", Q, 32'h0022007E);

    // Re-capture of identical data gives no pulse.
    applyStimulus(4'hF, 32'h0022007E, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("nochg_changed", {28'h0, changed}, 32'h0);
    checkOutput("nochg_count", {28'h0, upd_count}, 32'd3);

    // Saturation: clear, then toggle all four channels each cycle.
    applyStimulus(4'hF, 32'h0022007E, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("clear_count", {28'h0, upd_count}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'hF, (k % 2 == 0) ? 32'hFFDDFF81 : 32'h0022007E, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput($sformatf("sat_count_%0d", k), {28'h0, upd_count}, {27'h0, sat_exp[k]});
    end
    applyStimulus(4'hF, 32'h0022007E, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("clr_with_events", {28'h0, upd_count}, 32'd4);
    tick();
    checkOutput("clr_no_events", {28'h0, upd_count}, 32'd0);

    // Reset mid-operation overrides enable and clear, then capture resumes.
    applyStimulus(4'hF, 32'h12345607, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("midrst_Q", Q, 32'h0);
    checkOutput("midrst_changed", {28'h0, changed}, 32'h0);
    checkOutput("midrst_count", {28'h0, upd_count}, 32'd0);
    applyStimulus(4'hF, 32'h12345607, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("post_rst_Q", Q, 32'h12345607);
    checkOutput("post_rst_changed", {28'h0, changed}, 32'hF);
    checkOutput("post_rst_count", {28'h0, upd_count}, 32'd4);
`ifdef DREG_BANK_PARITY_EN
    checkOutput("post_rst_par", {28'h0, par}, 32'h5);
`endif

    // Transparent mode is suppressed while in reset.
    applyStimulus(4'hF, 32'hCAFEBABE, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("rst_transp_Q", Q, 32'h12345607);
    checkOutput("rst_transp_not_Q", not_Q, 32'hEDCBA9F8);
    tick();
    checkOutput("rst_transp_after", Q, 32'h0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
